// File: rtl/vga_ctl_pkg.sv
// Shared definitions for the pixel-pipeline sequencing controller: FSM state
// encodings and a small elaboration-time helper.
package vga_ctl_pkg;

   typedef enum logic [1:0] {
      VC_WAIT_LOCK = 2'd0,
      VC_RESET_GEN = 2'd1,
      VC_PREFILL   = 2'd2,
      VC_RUN       = 2'd3
   } vc_state_e;

   function automatic int vc_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vga_ctl_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted high-to-low transition of the debounced level.
module debounce
   import vga_ctl_pkg::*;
#(
   parameter int DB_CYCLES = 74250
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic fall_o
);

   localparam int CNT_W = $clog2(vc_max(DB_CYCLES, 1) + 1);

   logic             s1_q, s2_q;
   logic             lvl_q, lvl_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter tracks how long the synchronised input has disagreed with the
   // accepted level; any agreement restarts the count.
   always_comb begin
      lvl_d  = lvl_q;
      fall_d = 1'b0;
      cnt_d  = '0;
      if (s2_q != lvl_q) begin
         if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            lvl_d  = s2_q;
            fall_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         lvl_q  <= 1'b1;
         fall_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= btn_i;
         s2_q   <= s1_q;
         lvl_q  <= lvl_d;
         fall_q <= fall_d;
         cnt_q  <= cnt_d;
      end
   end

   assign fall_o = fall_q;

endmodule

// File: rtl/vga_ctl.sv
// Pixel-pipeline sequencer: waits for PLL lock, resets and prefills the
// generator/FIFO path, throttles the generator by fill level, applies pattern changes at frame ends.
module vga_ctl
   import vga_ctl_pkg::*;
#(
   parameter int NPAT      = 4,
   parameter int PW        = 2,
   parameter int DB_CYCLES = 74250,
   parameter int RST_CYC   = 16,
   parameter int FILL_HI   = 12,
   parameter int FILL_LO   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          locked,
   input  logic          but,
   input  logic [3:0]    fill,
   input  logic          gen_eof,
   input  logic          fetch,
   output logic          gen_rst,
   output logic          gen_cke,
   output logic          tx_en,
   output logic [PW-1:0] pattern,
   output logic          underrun,
   output logic [1:0]    state
);

   localparam int CNT_W = $clog2(vc_max(DB_CYCLES, RST_CYC) + 1);

   logic             lk_s1_q, lk_s2_q;
   vc_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gen_rst_q, gen_rst_d;
   logic             gen_cke_q, gen_cke_d;
   logic             tx_en_q, tx_en_d;
   logic             underrun_q, underrun_d;
   logic [PW-1:0]    pending_q, pending_d, pending_inc;
   logic [PW-1:0]    pattern_q, pattern_d;
   logic             btn_fall;

   debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_i (but),
      .fall_o(btn_fall)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      underrun_d = underrun_q;
      case (state_q)
         VC_WAIT_LOCK: if (lk_s2_q) state_d = VC_RESET_GEN;
         VC_RESET_GEN: begin
            if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = VC_PREFILL;
            else                              cnt_d   = cnt_q + 1'b1;
         end
         VC_PREFILL:   if (fill >= 4'(FILL_HI)) state_d = VC_RUN;
         VC_RUN: begin
            if (fetch && (fill == 4'd0)) begin
               state_d    = VC_RESET_GEN;
               underrun_d = 1'b1;
            end
         end
         default:      state_d = VC_WAIT_LOCK;
      endcase
      if (!lk_s2_q) begin
         state_d = VC_WAIT_LOCK;
         cnt_d   = '0;
      end
   end

   // Outputs are decoded from the next state so they register together with it.
   always_comb begin
      gen_rst_d = (state_d == VC_WAIT_LOCK) || (state_d == VC_RESET_GEN);
      tx_en_d   = (state_d == VC_RUN);
      gen_cke_d = 1'b0;
      case (state_d)
         VC_PREFILL: gen_cke_d = 1'b1;
         VC_RUN: begin
            if (state_q != VC_RUN)          gen_cke_d = 1'b1;
            else if (fill >= 4'(FILL_HI))   gen_cke_d = 1'b0;
            else if (fill <= 4'(FILL_LO))   gen_cke_d = 1'b1;
            else                            gen_cke_d = gen_cke_q;
         end
         default:    gen_cke_d = 1'b0;
      endcase
   end

   always_comb begin
      pending_inc = (pending_q == PW'(NPAT - 1)) ? '0 : pending_q + 1'b1;
      pending_d   = btn_fall ? pending_inc : pending_q;
      pattern_d   = pattern_q;
      if ((state_q == VC_WAIT_LOCK) || (state_q == VC_RESET_GEN)) pattern_d = pending_q;
      else if (gen_eof)                                           pattern_d = pending_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_s1_q    <= 1'b0;
         lk_s2_q    <= 1'b0;
         state_q    <= VC_WAIT_LOCK;
         cnt_q      <= '0;
         gen_rst_q  <= 1'b1;
         gen_cke_q  <= 1'b0;
         tx_en_q    <= 1'b0;
         underrun_q <= 1'b0;
         pending_q  <= '0;
         pattern_q  <= '0;
      end else begin
         lk_s1_q    <= locked;
         lk_s2_q    <= lk_s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gen_rst_q  <= gen_rst_d;
         gen_cke_q  <= gen_cke_d;
         tx_en_q    <= tx_en_d;
         underrun_q <= underrun_d;
         pending_q  <= pending_d;
         pattern_q  <= pattern_d;
      end
   end

   assign gen_rst  = gen_rst_q;
   assign gen_cke  = gen_cke_q;
   assign tx_en    = tx_en_q;
   assign underrun = underrun_q;
   assign pattern  = pattern_q;
   assign state    = state_q;

endmodule
